epa_macrocycle_gen: RTL and testbench

// - Generates the EPA macrocycle timebase consumed by the CSME scheduler: level i_macrocycle_b
//   (1 = periodic/FRT window, 0 = non-periodic window), a cycle-start strobe, phase and cycle number.
// - Phase is a ns accumulator advanced by CLK_NS per clock. It is realignable by the PTP slave
//   via a phase-load strobe, so all nodes' windows coincide.

---
 rtl/epa_macrocycle_gen_pkg.sv | 15 +
 rtl/epa_macrocycle_gen.sv | 157 +++++++++++++++
 tb/tb_epa_macrocycle_gen.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/epa_macrocycle_gen_pkg.sv
// Shared EPA timebase definitions: FSM state encodings and default timing constants.
package epa_macrocycle_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PERIODIC    = 2'd1,
        ST_NONPERIODIC = 2'd2
    } state_e;

    // 25 MHz timebase clock
    localparam int unsigned CLK_NS_DEF       = 40;
    // Shortest macrocycle the scheduler can handle
    localparam int unsigned MIN_CYCLE_NS_DEF = 1000;

endpackage

// File: rtl/epa_macrocycle_gen.sv
// EPA macrocycle timebase: ns phase accumulator with periodic / non-periodic
// window FSM, cycle-start strobe, cycle counter and PTP phase realignment.
module epa_macrocycle_gen
    import epa_macrocycle_gen_pkg::*;
#(
    parameter int unsigned CLK_NS       = CLK_NS_DEF,
    parameter int unsigned W            = 32,
    parameter int unsigned MIN_CYCLE_NS = MIN_CYCLE_NS_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_cycle_len,
    input  logic [W-1:0] i_periodic_len,
    input  logic         i_sync_vld,
    input  logic [W-1:0] i_sync_phase,
    output logic         o_macrocycle_b,
    output logic         o_cycle_start,
    output logic [W-1:0] o_phase_ns,
    output logic [15:0]  o_cycle_num,
    output logic         o_cfg_err,
    output logic         o_sync_err
);

    localparam logic [W-1:0] MIN_CYC_W = W'(MIN_CYCLE_NS);
    localparam logic [W:0]   CLK_STEP  = (W+1)'(CLK_NS);

    // A configuration is usable when the cycle is long enough and the
    // periodic window is non-empty and strictly shorter than the cycle.
    function automatic logic cfg_ok(input logic [W-1:0] cyc, input logic [W-1:0] per);
        return (cyc >= MIN_CYC_W) && (per != '0) && (per < cyc);
    endfunction

    state_e       state_q,     state_d;
    logic [W-1:0] phase_q,     phase_d;
    logic [W-1:0] cyc_q,       cyc_d;
    logic [W-1:0] per_q,       per_d;
    logic [15:0]  cycle_num_q, cycle_num_d;
    logic         start_q,     start_d;
    logic         cfg_err_q,   cfg_err_d;
    logic         sync_err_q,  sync_err_d;
    logic         mcb_q,       mcb_d;

    // Phase arithmetic is one bit wider so the boundary compares never wrap.
    logic [W:0]   nxt;
    logic [W-1:0] wrap_res;
    logic         new_ok;
    logic         sync_hit;

    // Next-state, phase advance, wrap and sync realignment.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cyc_d       = cyc_q;
        per_d       = per_q;
        cycle_num_d = cycle_num_q;
        start_d     = 1'b0;
        cfg_err_d   = cfg_err_q;
        sync_err_d  = 1'b0;
        nxt         = {1'b0, phase_q} + CLK_STEP;
        // True residue is below 2^W, so modulo-W subtraction is exact.
        wrap_res    = nxt[W-1:0] - cyc_q;
        new_ok      = cfg_ok(i_cycle_len, i_periodic_len);
        sync_hit    = i_sync_vld && (i_sync_phase < cyc_q);

        case (state_q)
            ST_IDLE: begin
                if (i_en) begin
                    if (new_ok) begin
                        state_d   = ST_PERIODIC;
                        phase_d   = '0;
                        cyc_d     = i_cycle_len;
                        per_d     = i_periodic_len;
                        start_d   = 1'b1;
                        cfg_err_d = 1'b0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_PERIODIC, ST_NONPERIODIC: begin
                if (sync_hit) begin
                    // Realignment beats the local increment and any wrap.
                    phase_d = i_sync_phase;
                    state_d = (i_sync_phase < per_q) ? ST_PERIODIC : ST_NONPERIODIC;
                end else begin
                    sync_err_d = i_sync_vld;
                    if (state_q == ST_PERIODIC) begin
                        phase_d = nxt[W-1:0];
                        if (nxt >= {1'b0, per_q}) begin
                            state_d = ST_NONPERIODIC;
                        end
                    end else if (nxt >= {1'b0, cyc_q}) begin
                        if (!i_en) begin
                            // Stop only at the boundary so the window is never cut short.
                            state_d = ST_IDLE;
                            phase_d = '0;
                        end else if (new_ok) begin
                            cyc_d       = i_cycle_len;
                            per_d       = i_periodic_len;
                            phase_d     = wrap_res;
                            state_d     = (wrap_res < i_periodic_len) ? ST_PERIODIC : ST_NONPERIODIC;
                            cycle_num_d = cycle_num_q + 16'd1;
                            start_d     = 1'b1;
                            cfg_err_d   = 1'b0;
                        end else begin
                            state_d   = ST_IDLE;
                            phase_d   = '0;
                            cfg_err_d = 1'b1;
                        end
                    end else begin
                        phase_d = nxt[W-1:0];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase

        mcb_d = (state_d == ST_PERIODIC);
    end

    // State and output registers; asynchronous reset clears everything at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            cyc_q       <= '0;
            per_q       <= '0;
            cycle_num_q <= '0;
            start_q     <= 1'b0;
            cfg_err_q   <= 1'b0;
            sync_err_q  <= 1'b0;
            mcb_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cyc_q       <= cyc_d;
            per_q       <= per_d;
            cycle_num_q <= cycle_num_d;
            start_q     <= start_d;
            cfg_err_q   <= cfg_err_d;
            sync_err_q  <= sync_err_d;
            mcb_q       <= mcb_d;
        end
    end

    assign o_macrocycle_b = mcb_q;
    assign o_cycle_start  = start_q;
    assign o_phase_ns     = phase_q;
    assign o_cycle_num    = cycle_num_q;
    assign o_cfg_err      = cfg_err_q;
    assign o_sync_err     = sync_err_q;

endmodule

// File: tb/tb_epa_macrocycle_gen.sv
// Bench for epa_macrocycle_gen: directed scenarios with literal expectations
// plus randomized traffic, all cross-checked every cycle against a phase-based model.
module tb_epa_macrocycle_gen;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_en = 1'b0;
    logic [31:0] i_cycle_len = '0;
    logic [31:0] i_periodic_len = '0;
    logic        i_sync_vld = 1'b0;
    logic [31:0] i_sync_phase = '0;
    logic        o_macrocycle_b;
    logic        o_cycle_start;
    logic [31:0] o_phase_ns;
    logic [15:0] o_cycle_num;
    logic        o_cfg_err;
    logic        o_sync_err;

    epa_macrocycle_gen #(.CLK_NS(40), .W(32), .MIN_CYCLE_NS(1000)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_en           (i_en),
        .i_cycle_len    (i_cycle_len),
        .i_periodic_len (i_periodic_len),
        .i_sync_vld     (i_sync_vld),
        .i_sync_phase   (i_sync_phase),
        .o_macrocycle_b (o_macrocycle_b),
        .o_cycle_start  (o_cycle_start),
        .o_phase_ns     (o_phase_ns),
        .o_cycle_num    (o_cycle_num),
        .o_cfg_err      (o_cfg_err),
        .o_sync_err     (o_sync_err)
    );

    initial forever #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model only tracks "running", the phase and the latched config;
    // the window level is derived as phase < periodic length.
    bit          m_run;
    logic [31:0] m_phase, m_cyc, m_per;
    logic [15:0] m_num;
    bit          m_start, m_cfg_err, m_sync_err;

    function automatic bit valid_cfg(input logic [31:0] c, input logic [31:0] p);
        return (c >= 32'd1000) && (p != 32'd0) && (p < c);
    endfunction

    task automatic model_reset();
        m_run = 0; m_phase = '0; m_cyc = '0; m_per = '0; m_num = '0;
        m_start = 0; m_cfg_err = 0; m_sync_err = 0;
    endtask

    task automatic model_step();
        bit s_start = 0;
        bit s_serr = 0;
        logic [32:0] n;
        if (!m_run) begin
            if (i_en) begin
                if (valid_cfg(i_cycle_len, i_periodic_len)) begin
                    m_run = 1; m_phase = '0; m_cyc = i_cycle_len; m_per = i_periodic_len;
                    s_start = 1; m_cfg_err = 0;
                end else begin
                    m_cfg_err = 1;
                end
            end
        end else if (i_sync_vld && (i_sync_phase < m_cyc)) begin
            m_phase = i_sync_phase;
        end else begin
            s_serr = i_sync_vld;
            n = {1'b0, m_phase} + 33'd40;
            if ((m_phase >= m_per) && (n >= {1'b0, m_cyc})) begin
                if (!i_en) begin
                    m_run = 0; m_phase = '0;
                end else if (valid_cfg(i_cycle_len, i_periodic_len)) begin
                    m_phase = 32'(n - {1'b0, m_cyc});
                    m_cyc = i_cycle_len; m_per = i_periodic_len;
                    m_num = m_num + 16'd1; s_start = 1; m_cfg_err = 0;
                end else begin
                    m_run = 0; m_phase = '0; m_cfg_err = 1;
                end
            end else begin
                m_phase = n[31:0];
            end
        end
        m_start = s_start;
        m_sync_err = s_serr;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge i_clk or negedge i_rst_n);
            if (!i_rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge i_clk);
        if (cmp_on) begin
            logic exp_mb;
            exp_mb = m_run && (m_phase < m_per);
            n_checks++;
            if ({o_macrocycle_b, o_cycle_start, o_phase_ns, o_cycle_num, o_cfg_err, o_sync_err} !==
                {exp_mb, m_start, m_phase, m_num, m_cfg_err, m_sync_err}) begin
                n_errors++;
                $display("FAIL cycle t=%0t: dut mb=%b st=%b ph=%0d num=%0d ce=%b se=%b / model mb=%b st=%b ph=%0d num=%0d ce=%b se=%b",
                         $time, o_macrocycle_b, o_cycle_start, o_phase_ns, o_cycle_num, o_cfg_err, o_sync_err,
                         exp_mb, m_start, m_phase, m_num, m_cfg_err, m_sync_err);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic set_cfg(input int c, input int p);
        i_cycle_len = 32'(c);
        i_periodic_len = 32'(p);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int clks;
        int guard;
        int last_start;
        int per_len [0:1];

        tick(2);
        cmp_on = 1'b1;
        check("reset_phase", 64'(o_phase_ns), 64'd0);
        check("reset_mb", 64'(o_macrocycle_b), 64'd0);
        check("reset_num", 64'(o_cycle_num), 64'd0);
        i_rst_n = 1'b1;
        tick(1);

        // Basic 1000/400 cycle: 10 clks high, 15 low
        set_cfg(1000, 400); i_en = 1'b1;
        tick(1);
        check("start_after_en", 64'(o_cycle_start), 64'd1);
        check("start_phase", 64'(o_phase_ns), 64'd0);
        check("start_mb", 64'(o_macrocycle_b), 64'd1);
        tick(9);
        check("per_last_phase", 64'(o_phase_ns), 64'd360);
        check("per_last_mb", 64'(o_macrocycle_b), 64'd1);
        tick(1);
        check("nonper_phase", 64'(o_phase_ns), 64'd400);
        check("nonper_mb", 64'(o_macrocycle_b), 64'd0);
        tick(14);
        check("pre_wrap_phase", 64'(o_phase_ns), 64'd960);
        tick(1);
        check("wrap_start", 64'(o_cycle_start), 64'd1);
        check("wrap_phase", 64'(o_phase_ns), 64'd0);
        check("wrap_num", 64'(o_cycle_num), 64'd1);

        // Sync to 600 mid-periodic, then a rejected sync to 1200
        tick(2);
        i_sync_vld = 1'b1; i_sync_phase = 32'd600;
        tick(1);
        i_sync_vld = 1'b0;
        check("sync_phase", 64'(o_phase_ns), 64'd600);
        check("sync_mb", 64'(o_macrocycle_b), 64'd0);
        check("sync_no_start", 64'(o_cycle_start), 64'd0);
        i_sync_vld = 1'b1; i_sync_phase = 32'd1200;
        tick(1);
        i_sync_vld = 1'b0;
        check("sync_err_pulse", 64'(o_sync_err), 64'd1);
        check("sync_err_phase", 64'(o_phase_ns), 64'd640);
        tick(1);
        check("sync_err_clear", 64'(o_sync_err), 64'd0);

        // Asynchronous reset in the non-periodic window
        #2 i_rst_n = 1'b0;
        #1;
        check("async_rst_phase", 64'(o_phase_ns), 64'd0);
        check("async_rst_num", 64'(o_cycle_num), 64'd0);
        check("async_rst_mb", 64'(o_macrocycle_b), 64'd0);
        i_en = 1'b0;
        tick(2);
        i_rst_n = 1'b1;

        // Invalid configs keep the block idle
        set_cfg(1000, 0); i_en = 1'b1;
        tick(1);
        check("cfg_err_per0", 64'(o_cfg_err), 64'd1);
        check("cfg_err_idle", 64'(o_macrocycle_b), 64'd0);
        set_cfg(500, 400);
        tick(1);
        check("cfg_err_cyc500", 64'(o_cfg_err), 64'd1);
        set_cfg(1000, 400);
        tick(1);
        check("cfg_fixed_start", 64'(o_cycle_start), 64'd1);
        check("cfg_err_cleared", 64'(o_cfg_err), 64'd0);

        // Shrink periodic window mid-cycle: effective only from next cycle
        tick(2);
        set_cfg(1000, 200);
        tick(7);
        check("old_window_360", 64'(o_macrocycle_b), 64'd1);
        tick(1);
        check("old_window_end", 64'(o_macrocycle_b), 64'd0);
        tick(15);
        check("newper_start", 64'(o_cycle_start), 64'd1);
        tick(4);
        check("new_window_160", 64'(o_macrocycle_b), 64'd1);
        tick(1);
        check("new_window_end", 64'(o_macrocycle_b), 64'd0);

        // Non-multiple cycle length 1020: residues 20,0; periods 26,25
        set_cfg(1020, 400);
        tick(20);
        check("c1020_first_start", 64'(o_cycle_start), 64'd1);
        check("c1020_first_phase", 64'(o_phase_ns), 64'd0);
        clks = 0;
        last_start = 0;
        for (int k = 1; k <= 50; k++) begin
            guard = 0;
            do begin
                tick(1); clks++; guard++;
            end while (!o_cycle_start && guard < 40);
            if (guard >= 40) begin
                check("c1020_start_timeout", 64'd0, 64'd1);
                break;
            end
            if (k <= 2) begin
                per_len[k-1] = clks - last_start;
                check(k == 1 ? "c1020_res1" : "c1020_res2", 64'(o_phase_ns), k == 1 ? 64'd20 : 64'd0);
            end
            last_start = clks;
        end
        check("c1020_period1", 64'(per_len[0]), 64'd26);
        check("c1020_period2", 64'(per_len[1]), 64'd25);
        check("c1020_50_cycles", 64'(clks), 64'd1275);

        // Disable at phase 200: window completes, then idle without a start pulse
        tick(5);
        i_en = 1'b0;
        tick(4);
        check("dis_still_high", 64'(o_macrocycle_b), 64'd1);
        tick(1);
        check("dis_window_end", 64'(o_macrocycle_b), 64'd0);
        tick(15);
        check("dis_last_phase", 64'(o_phase_ns), 64'd1000);
        tick(1);
        check("dis_idle_phase", 64'(o_phase_ns), 64'd0);
        check("dis_no_start", 64'(o_cycle_start), 64'd0);
        tick(5);
        check("dis_stays_idle", 64'(o_macrocycle_b), 64'd0);

        // Randomized traffic, checked only by the per-cycle compare
        set_cfg(1000, 400); i_en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            tick(1);
            i_sync_vld = 1'b0;
            i_rst_n = 1'b1;
            if ($urandom_range(0, 99) < 8) i_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 2) begin
                i_cycle_len = 32'($urandom_range(800, 1500));
                i_periodic_len = 32'($urandom_range(0, 1520));
            end
            if ($urandom_range(0, 19) == 0) begin
                i_sync_vld = 1'b1;
                i_sync_phase = 32'($urandom_range(0, 1600));
            end
            if ($urandom_range(0, 999) == 0) i_rst_n = 1'b0;
        end
        tick(1);
        i_rst_n = 1'b1;
        i_sync_vld = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
